// File: rtl/dcpu16_bootldr_pkg.sv
// Shared definitions for the dcpu16 boot loader: FSM state encodings,
// stream byte order and small helpers for byte pairing and checksumming.
package dcpu16_bootldr_pkg;

  // Loader FSM states, 4-bit encodings in stream order.
  typedef enum logic [3:0] {
    HDR_HI = 4'd0,
    HDR_LO = 4'd1,
    DAT_HI = 4'd2,
    DAT_LO = 4'd3,
    WRITE  = 4'd4,
    SUM_HI = 4'd5,
    SUM_LO = 4'd6,
    DONE   = 4'd7,
    ERR    = 4'd8
  } ld_state_e;

  // Stream words arrive high byte first.
  localparam logic BYTE_ORDER_BIG = 1'b1;

  // Combine the held first byte with the current byte into a word.
  function automatic logic [15:0] pair_bytes(input logic [7:0] first_b,
                                             input logic [7:0] second_b);
    if (BYTE_ORDER_BIG) begin
      return {first_b, second_b};
    end else begin
      return {second_b, first_b};
    end
  endfunction

  // Running checksum: 16-bit add, carry out of bit 15 is discarded.
  function automatic logic [15:0] csum_add(input logic [15:0] a,
                                           input logic [15:0] b);
    return a + b;
  endfunction

  // States in which the loader consumes bytes from the stream.
  function automatic logic accepts_bytes(input ld_state_e s);
    case (s)
      HDR_HI, HDR_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dcpu16_bootldr.sv
// dcpu16 boot loader: pairs incoming bytes into words, writes them into
// program memory over a stb/wre/ack port, verifies the trailing checksum
// and only then releases the CPU from reset.
module dcpu16_bootldr
  import dcpu16_bootldr_pkg::*;
#(
  parameter int unsigned     AW   = 16,
  parameter logic [AW-1:0]   BASE = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_dat,
  input  logic          rx_stb,
  output logic          rx_rdy,
  output logic [AW-1:0] ld_adr,
  output logic [15:0]   ld_dto,
  output logic          ld_stb,
  output logic          ld_wre,
  input  logic          ld_ack,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  ld_state_e     state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   sum_q, sum_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic [AW-1:0] ld_adr_q, ld_adr_d;
  logic [15:0]   ld_dto_q, ld_dto_d;
  logic          ld_stb_q, ld_stb_d;
  logic          ld_wre_q;
  logic          cpu_rst_q, cpu_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept_s;
  logic [15:0]   word_s;

  assign accept_s = rx_stb & rx_rdy_q;
  assign word_s   = pair_bytes(hi_q, rx_dat);

  // Next-state logic for the FSM, datapath and registered outputs.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    count_d  = count_q;
    sum_d    = sum_q;
    ld_adr_d = ld_adr_q;
    ld_dto_d = ld_dto_q;
    ld_stb_d = ld_stb_q;
    case (state_q)
      HDR_HI, DAT_HI, SUM_HI: begin
        if (accept_s) begin
          hi_d    = rx_dat;
          state_d = ld_state_e'(state_q + 4'd1);
        end else begin
          hi_d    = hi_q;
        end
      end
      HDR_LO: begin
        if (accept_s) begin
          count_d = word_s;
          sum_d   = word_s;
          state_d = (word_s != 16'd0) ? DAT_HI : SUM_HI;
        end else begin
          count_d = count_q;
        end
      end
      DAT_LO: begin
        if (accept_s) begin
          ld_dto_d = word_s;
          sum_d    = csum_add(sum_q, word_s);
          ld_stb_d = 1'b1;
          state_d  = WRITE;
        end else begin
          ld_stb_d = ld_stb_q;
        end
      end
      WRITE: begin
        // An ack only counts while the strobe is actually up.
        if (ld_stb_q && ld_ack) begin
          ld_stb_d = 1'b0;
          ld_adr_d = ld_adr_q + {{(AW-1){1'b0}}, 1'b1};
          count_d  = count_q - 16'd1;
          state_d  = (count_q == 16'd1) ? SUM_HI : DAT_HI;
        end else begin
          ld_stb_d = ld_stb_q;
        end
      end
      SUM_LO: begin
        if (accept_s) begin
          state_d = (word_s == sum_q) ? DONE : ERR;
        end else begin
          state_d = SUM_LO;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = HDR_HI;
    endcase
    // Status outputs are registered copies of what the next state implies.
    rx_rdy_d  = accepts_bytes(state_d);
    cpu_rst_d = (state_d != DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  // State and output registers; async reset abandons any partial load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HDR_HI;
      hi_q      <= 8'h00;
      count_q   <= 16'h0000;
      sum_q     <= 16'h0000;
      rx_rdy_q  <= 1'b0;
      ld_adr_q  <= BASE;
      ld_dto_q  <= 16'h0000;
      ld_stb_q  <= 1'b0;
      ld_wre_q  <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      rx_rdy_q  <= rx_rdy_d;
      ld_adr_q  <= ld_adr_d;
      ld_dto_q  <= ld_dto_d;
      ld_stb_q  <= ld_stb_d;
      ld_wre_q  <= ld_stb_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rx_rdy  = rx_rdy_q;
  assign ld_adr  = ld_adr_q;
  assign ld_dto  = ld_dto_q;
  assign ld_stb  = ld_stb_q;
  assign ld_wre  = ld_wre_q;
  assign cpu_rst = cpu_rst_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dcpu16_bootldr.sv
// Directed bench for dcpu16_bootldr. Two instances share one byte stream:
// dut0 loads at BASE=0x0000, dut1 at BASE=0xFFFF to exercise address wrap.
module tb_dcpu16_bootldr;
  import dcpu16_bootldr_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic        ld_ack;

  logic        rx_rdy0, ld_stb0, ld_wre0, cpu_rst0, done0, err0;
  logic [15:0] ld_adr0, ld_dto0;
  logic        rx_rdy1, ld_stb1, ld_wre1, cpu_rst1, done1, err1;
  logic [15:0] ld_adr1, ld_dto1;

  int          n_vec;
  int          n_miss;

  int          ack_dly;
  logic        ack_idle;
  int          stb_cnt;
  int          last_len;
  logic [15:0] cap_adr, cap_dto;
  logic [15:0] wq_adr0[$];
  logic [15:0] wq_adr1[$];
  logic [15:0] wq_dto0[$];
  logic [15:0] wq_dto1[$];
  logic [7:0]  bytes_q[$];
  logic [15:0] exp_w[$];

  dcpu16_bootldr #(.AW(16), .BASE(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_rdy(rx_rdy0),
    .ld_adr(ld_adr0), .ld_dto(ld_dto0), .ld_stb(ld_stb0), .ld_wre(ld_wre0),
    .ld_ack(ld_ack), .cpu_rst(cpu_rst0), .done(done0), .err(err0)
  );

  dcpu16_bootldr #(.AW(16), .BASE(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_stb(rx_stb), .rx_rdy(rx_rdy1),
    .ld_adr(ld_adr1), .ld_dto(ld_dto1), .ld_stb(ld_stb1), .ld_wre(ld_wre1),
    .ld_ack(ld_ack), .cpu_rst(cpu_rst1), .done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory responder: acks ack_dly cycles into each strobe, records writes,
  // and checks the write-phase invariants every cycle.
  initial begin
    stb_cnt  = 0;
    last_len = 0;
    forever begin
      @(negedge clk);
      chk("wre0_eq_stb", {31'd0, ld_wre0}, {31'd0, ld_stb0});
      chk("wre1_eq_stb", {31'd0, ld_wre1}, {31'd0, ld_stb1});
      chk("stb1_eq_stb0", {31'd0, ld_stb1}, {31'd0, ld_stb0});
      chk("not_done_and_err", {31'd0, done0 & err0}, 32'd0);
      if (ld_stb0) begin
        stb_cnt = stb_cnt + 1;
        chk("rdy_in_write", {31'd0, rx_rdy0}, 32'd0);
        if (stb_cnt == 1) begin
          cap_adr = ld_adr0;
          cap_dto = ld_dto0;
        end else begin
          chk("adr_stable", {16'd0, ld_adr0}, {16'd0, cap_adr});
          chk("dto_stable", {16'd0, ld_dto0}, {16'd0, cap_dto});
        end
        if (stb_cnt == ack_dly) begin
          ld_ack   = 1'b1;
          last_len = stb_cnt;
          wq_adr0.push_back(ld_adr0);
          wq_adr1.push_back(ld_adr1);
          wq_dto0.push_back(ld_dto0);
          wq_dto1.push_back(ld_dto1);
        end else begin
          ld_ack = 1'b0;
        end
      end else begin
        stb_cnt = 0;
        ld_ack  = ack_idle;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    rx_stb = 1'b0;
    rx_dat = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rx_rdy", {31'd0, rx_rdy0}, 32'd0);
    chk("rst_ld_stb", {31'd0, ld_stb0}, 32'd0);
    chk("rst_ld_adr0", {16'd0, ld_adr0}, 32'h0000_0000);
    chk("rst_ld_adr1", {16'd0, ld_adr1}, 32'h0000_FFFF);
    chk("rst_ld_dto", {16'd0, ld_dto0}, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst0}, 32'd1);
    chk("rst_done_err", {30'd0, done0, err0}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rx_rdy_after_rst", {31'd0, rx_rdy0}, 32'd1);
    wq_adr0.delete(); wq_adr1.delete(); wq_dto0.delete(); wq_dto1.delete();
    bytes_q.delete(); exp_w.delete();
  endtask

  task automatic push_word(input logic [15:0] w);
    bytes_q.push_back(w[15:8]);
    bytes_q.push_back(w[7:0]);
  endtask

  // Offer one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_dat = b;
    rx_stb = 1'b1;
    n = 0;
    while (rx_rdy0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("rx_accept_in_time", {31'd0, (n < 200)}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // rx_stb stays high across the whole stream, including write phases.
  task automatic send_all();
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    rx_stb = 1'b0;
  endtask

  task automatic check_writes();
    chk("write_count0", wq_adr0.size(), exp_w.size());
    chk("write_count1", wq_adr1.size(), exp_w.size());
    if (wq_adr0.size() == exp_w.size() && wq_adr1.size() == exp_w.size()) begin
      foreach (exp_w[i]) begin
        logic [15:0] a1;
        a1 = 16'hFFFF + i[15:0];
        chk("wr_adr0", {16'd0, wq_adr0[i]}, {16'd0, i[15:0]});
        chk("wr_adr1", {16'd0, wq_adr1[i]}, {16'd0, a1});
        chk("wr_dto0", {16'd0, wq_dto0[i]}, {16'd0, exp_w[i]});
        chk("wr_dto1", {16'd0, wq_dto1[i]}, {16'd0, exp_w[i]});
      end
    end
  endtask

  task automatic check_status(input logic d, input logic e, input logic c);
    chk("done0", {31'd0, done0}, {31'd0, d});
    chk("err0", {31'd0, err0}, {31'd0, e});
    chk("cpu_rst0", {31'd0, cpu_rst0}, {31'd0, c});
    chk("done1", {31'd0, done1}, {31'd0, d});
    chk("err1", {31'd0, err1}, {31'd0, e});
    chk("cpu_rst1", {31'd0, cpu_rst1}, {31'd0, c});
    chk("rx_rdy_terminal", {31'd0, rx_rdy0}, 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b0;
    rx_dat   = 8'h00;
    rx_stb   = 1'b0;
    ld_ack   = 1'b0;
    ack_dly  = 1;
    ack_idle = 1'b0;

    // 1: N=2, good checksum, ack one clock after strobe.
    do_reset();
    push_word(16'h0002); push_word(16'h1234); push_word(16'hABCD); push_word(16'hBE03);
    exp_w.push_back(16'h1234); exp_w.push_back(16'hABCD);
    send_all();
    check_writes();
    check_status(1'b1, 1'b0, 1'b0);
    chk("len_single", last_len, 32'd1);

    // 2: same stream, bad checksum.
    do_reset();
    push_word(16'h0002); push_word(16'h1234); push_word(16'hABCD); push_word(16'hBE04);
    exp_w.push_back(16'h1234); exp_w.push_back(16'hABCD);
    send_all();
    check_writes();
    check_status(1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_status(1'b0, 1'b1, 1'b1);

    // 3: N=0, C=0 -> done right after the fourth byte, no writes.
    do_reset();
    push_word(16'h0000); push_word(16'h0000);
    send_all();
    check_status(1'b1, 1'b0, 1'b0);
    check_writes();

    // 4: N=1, ack delayed 5 clocks, stray acks while strobe is low.
    do_reset();
    ack_dly  = 5;
    ack_idle = 1'b1;
    push_word(16'h0001); push_word(16'h5555); push_word(16'h5556);
    exp_w.push_back(16'h5555);
    send_all();
    ack_idle = 1'b0;
    check_writes();
    chk("len_delayed", last_len, 32'd5);
    check_status(1'b1, 1'b0, 1'b0);

    // 5: N=2, words 1/2, C=5; dut1 writes 0xFFFF then wraps to 0x0000.
    do_reset();
    ack_dly = 1;
    push_word(16'h0002); push_word(16'h0001); push_word(16'h0002); push_word(16'h0005);
    exp_w.push_back(16'h0001); exp_w.push_back(16'h0002);
    send_all();
    check_writes();
    check_status(1'b1, 1'b0, 1'b0);

    // 6: reset during the first write of an N=3 load, then a fresh load.
    do_reset();
    ack_dly = 50;
    push_word(16'h0003); push_word(16'hCAFE);
    send_all();
    @(negedge clk);
    chk("midwr_stb_up", {31'd0, ld_stb0}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stb", {31'd0, ld_stb0}, 32'd0);
    chk("midrst_wre", {31'd0, ld_wre0}, 32'd0);
    chk("midrst_cpu_rst", {31'd0, cpu_rst0}, 32'd1);
    chk("midrst_rx_rdy", {31'd0, rx_rdy0}, 32'd0);
    chk("midrst_state", {28'd0, dut0.state_q}, {28'd0, HDR_HI});
    chk("midrst_adr", {16'd0, ld_adr0}, 32'd0);
    ack_dly = 1;
    do_reset();
    push_word(16'h0002); push_word(16'h1234); push_word(16'hABCD); push_word(16'hBE03);
    exp_w.push_back(16'h1234); exp_w.push_back(16'hABCD);
    send_all();
    check_writes();
    check_status(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog in case a wait somewhere is not bounded as intended.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
